// File: rtl/ldst_pkg.sv
`default_nettype none
// ============================================================================
// Package : ldst_pkg
// Purpose : Shared types for the load/store functional unit: access-size
//           encoding, writeback exception codes, opcode/type bit positions
//           and the per-entry metadata kept for each outstanding load.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ldst_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } ldst_size_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10
  } ldst_exc_e;

  localparam int OPC_STORE_BIT     = 3;
  localparam int TYPE_UNSIGNED_BIT = 2;

  // Metadata for one outstanding load; the tag and address are held in
  // parallel arrays in the unit because their widths are parameters.
  typedef struct packed {
    logic       discard;
    ldst_size_e size;
    logic       is_unsigned;
  } ld_meta_t;

endpackage
`default_nettype wire

// File: rtl/ldst_fu_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface : ldst_fu_pipe_if
// Purpose   : Bundles the issue port, data-cache request/response port and
//             writeback bus of the load/store unit.
// Modports  : slave  - the load/store unit (receives issue, drives D$ req/wb)
//             master - the environment (issue logic, D$, writeback consumer)
// Rev       : 1.0  initial release
// ============================================================================
interface ldst_fu_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
);
  // issue
  logic              valid;
  logic              ready;
  logic [4:0]        opcode;
  logic [3:0]        ld_st_type;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic [XLEN-1:0]   imm;
  logic [TAG_W-1:0]  tag;
  logic              flush;
  // data cache
  logic              dc_req_valid;
  logic              dc_req_ready;
  logic              dc_req_we;
  logic [XLEN-1:0]   dc_req_addr;
  logic [XLEN-1:0]   dc_req_wdata;
  logic [XLEN/8-1:0] dc_req_be;
  logic              dc_resp_valid;
  logic [XLEN-1:0]   dc_resp_rdata;
  // writeback
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [XLEN-1:0]   wb_result;
  logic [XLEN-1:0]   wb_address;
  logic [1:0]        wb_exc;

  modport slave (
    input  valid, opcode, ld_st_type, rs1, rs2, imm, tag, flush,
    input  dc_req_ready, dc_resp_valid, dc_resp_rdata,
    output ready, dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be,
    output wb_valid, wb_tag, wb_result, wb_address, wb_exc
  );

  modport master (
    output valid, opcode, ld_st_type, rs1, rs2, imm, tag, flush,
    output dc_req_ready, dc_resp_valid, dc_resp_rdata,
    input  ready, dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata, dc_req_be,
    input  wb_valid, wb_tag, wb_result, wb_address, wb_exc
  );
endinterface
`default_nettype wire

// File: rtl/ldst_load_fmt.sv
`default_nettype none
// ============================================================================
// Module  : ldst_load_fmt
// Purpose : Combinational load-data formatter. Shifts the addressed bytes of
//           a full aligned word down to bit 0, keeps 2^size bytes and zero-
//           or sign-extends to XLEN.
// Ports   : rdata (in, XLEN), offset (in, byte offset in word), size (in),
//           is_unsigned (in), result (out, XLEN)
// Rev     : 1.0  initial release
// ============================================================================
module ldst_load_fmt
  import ldst_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  ldst_size_e                 size,
  input  logic                       is_unsigned,
  output logic [XLEN-1:0]            result
);

  logic [XLEN-1:0] shifted;
  logic            sign_bit;
  int              nbits;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    nbits    = 8 << int'(size);
    if (nbits > XLEN) nbits = XLEN;
    sign_bit = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (i == nbits - 1) sign_bit = shifted[i];
    end
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? shifted[i] : (sign_bit & ~is_unsigned);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldst_fu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : ldst_fu_pipe
// Purpose : Pipelined load/store unit. One issue register (S1) computes the
//           effective address, alignment/size faults and store lane data.
//           Outstanding loads are tracked in an in-order FIFO; responses pop
//           the head and are formatted onto a registered writeback bus.
// Ports   : clk, rst_n (async active-low), bus (ldst_fu_pipe_if.slave:
//           issue, flush, D$ request/response, writeback)
// Rev     : 1.0  initial release
// ============================================================================
module ldst_fu_pipe
  import ldst_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ldst_fu_pipe_if.slave  bus
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // ---------------- S1 issue register ----------------
  logic             s1_valid_q, s1_valid_d;
  logic             s1_store_q, s1_store_d;
  ldst_size_e       s1_size_q,  s1_size_d;
  logic             s1_uns_q,   s1_uns_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic [XLEN-1:0]  s1_addr_q,  s1_addr_d;
  logic [XLEN-1:0]  s1_data_q,  s1_data_d;

  // ---------------- load FIFO ----------------
  logic [PTR_W:0]   head_q, head_d, tail_q, tail_d;
  ld_meta_t         meta_q [DEPTH];
  ld_meta_t         meta_d [DEPTH];
  logic [TAG_W-1:0] ftag_q [DEPTH];
  logic [TAG_W-1:0] ftag_d [DEPTH];
  logic [XLEN-1:0]  faddr_q [DEPTH];
  logic [XLEN-1:0]  faddr_d [DEPTH];

  // ---------------- writeback register ----------------
  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_tag_q,   wb_tag_d;
  logic [XLEN-1:0]  wb_result_q, wb_result_d;
  logic [XLEN-1:0]  wb_address_q, wb_address_d;
  ldst_exc_e        wb_exc_q,   wb_exc_d;

  logic [OFF_W-1:0] s1_off, align_mask;
  logic             s1_illegal, s1_misalign, s1_fault;
  ldst_exc_e        s1_exc;
  logic [NB-1:0]    s1_be;
  logic             fifo_empty, fifo_full, fifo_room;
  logic             pop, push, req_valid, handshake, depart, capture;
  logic [PTR_W-1:0] head_idx;
  ld_meta_t         head_meta;
  logic [XLEN-1:0]  fmt_result;
  logic             unused_bits;

  assign unused_bits = ^{bus.opcode[4], bus.opcode[2:0], bus.ld_st_type[3]};

  // S1 fault detection and lane formatting
  assign s1_off = s1_addr_q[OFF_W-1:0];

  always_comb begin
    for (int i = 0; i < OFF_W; i++) align_mask[i] = (i < int'(s1_size_q));
    for (int i = 0; i < NB; i++) begin
      s1_be[i] = s1_valid_q && (i >= int'(s1_off)) &&
                 (i < int'(s1_off) + (1 << int'(s1_size_q)));
    end
  end

  assign s1_illegal  = int'(s1_size_q) > OFF_W;
  assign s1_misalign = |(s1_off & align_mask);
  assign s1_fault    = s1_illegal || s1_misalign;
  assign s1_exc      = s1_illegal ? EXC_ILLEGAL : (s1_misalign ? EXC_MISALIGN : EXC_NONE);

  // FIFO status; a pop in the same cycle frees an entry for a push
  assign head_idx   = head_q[PTR_W-1:0];
  assign head_meta  = meta_q[head_idx];
  assign fifo_empty = (head_q == tail_q);
  assign fifo_full  = (head_q[PTR_W] != tail_q[PTR_W]) &&
                      (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign pop        = bus.dc_resp_valid && !fifo_empty;
  assign fifo_room  = !fifo_full || pop;

  // Stores and faults yield the writeback slot to a returning load, so they
  // wait out any response cycle. Requests are also withheld during a flush
  // so no D$ access can be issued for an op that is being killed.
  assign req_valid = s1_valid_q && !bus.flush && !s1_fault &&
                     (s1_store_q ? !bus.dc_resp_valid : fifo_room);
  assign handshake = req_valid && bus.dc_req_ready;
  assign depart    = s1_valid_q && !bus.flush &&
                     (s1_fault ? !bus.dc_resp_valid : handshake);
  assign push      = handshake && !s1_store_q;
  assign bus.ready = !s1_valid_q || depart;
  assign capture   = bus.valid && bus.ready && !bus.flush;

  assign bus.dc_req_valid = req_valid;
  assign bus.dc_req_we    = s1_valid_q && s1_store_q;
  assign bus.dc_req_addr  = s1_valid_q ? {s1_addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus.dc_req_wdata = s1_valid_q ? (s1_data_q << {s1_off, 3'b000}) : '0;
  assign bus.dc_req_be    = s1_be;

  ldst_load_fmt #(.XLEN(XLEN)) u_fmt (
    .rdata       (bus.dc_resp_rdata),
    .offset      (faddr_q[head_idx][OFF_W-1:0]),
    .size        (head_meta.size),
    .is_unsigned (head_meta.is_unsigned),
    .result      (fmt_result)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_store_d = s1_store_q;
    s1_size_d  = s1_size_q;
    s1_uns_d   = s1_uns_q;
    s1_tag_d   = s1_tag_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    if (bus.flush) begin
      s1_valid_d = 1'b0;
    end else if (capture) begin
      s1_valid_d = 1'b1;
      s1_store_d = bus.opcode[OPC_STORE_BIT];
      s1_size_d  = ldst_size_e'(bus.ld_st_type[1:0]);
      s1_uns_d   = bus.ld_st_type[TYPE_UNSIGNED_BIT];
      s1_tag_d   = bus.tag;
      s1_addr_d  = bus.rs1 + bus.imm;
      s1_data_d  = bus.rs2;
    end else if (depart) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + PTR_ONE : head_q;
    tail_d  = push ? tail_q + PTR_ONE : tail_q;
    meta_d  = meta_q;
    ftag_d  = ftag_q;
    faddr_d = faddr_q;
    if (push) begin
      meta_d[tail_q[PTR_W-1:0]]  = '{discard: 1'b0, size: s1_size_q, is_unsigned: s1_uns_q};
      ftag_d[tail_q[PTR_W-1:0]]  = s1_tag_q;
      faddr_d[tail_q[PTR_W-1:0]] = s1_addr_q;
    end
    // Killed loads keep their slot so their responses still pop in order
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) meta_d[i].discard = 1'b1;
    end
  end

  always_comb begin
    wb_valid_d   = 1'b0;
    wb_tag_d     = '0;
    wb_result_d  = '0;
    wb_address_d = '0;
    wb_exc_d     = EXC_NONE;
    if (pop && !head_meta.discard && !bus.flush) begin
      wb_valid_d   = 1'b1;
      wb_tag_d     = ftag_q[head_idx];
      wb_result_d  = fmt_result;
      wb_address_d = faddr_q[head_idx];
    end else if (depart && (s1_store_q || s1_fault)) begin
      wb_valid_d   = 1'b1;
      wb_tag_d     = s1_tag_q;
      wb_address_d = s1_addr_q;
      wb_exc_d     = s1_exc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_store_q   <= 1'b0;
      s1_size_q    <= SZ_B;
      s1_uns_q     <= 1'b0;
      s1_tag_q     <= '0;
      s1_addr_q    <= '0;
      s1_data_q    <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      wb_valid_q   <= 1'b0;
      wb_tag_q     <= '0;
      wb_result_q  <= '0;
      wb_address_q <= '0;
      wb_exc_q     <= EXC_NONE;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_store_q   <= s1_store_d;
      s1_size_q    <= s1_size_d;
      s1_uns_q     <= s1_uns_d;
      s1_tag_q     <= s1_tag_d;
      s1_addr_q    <= s1_addr_d;
      s1_data_q    <= s1_data_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      wb_valid_q   <= wb_valid_d;
      wb_tag_q     <= wb_tag_d;
      wb_result_q  <= wb_result_d;
      wb_address_q <= wb_address_d;
      wb_exc_q     <= wb_exc_d;
    end
  end

  // Entry payload needs no reset: the pointers define which entries are live
  always_ff @(posedge clk) begin
    meta_q  <= meta_d;
    ftag_q  <= ftag_d;
    faddr_q <= faddr_d;
  end

  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_tag     = wb_tag_q;
  assign bus.wb_result  = wb_result_q;
  assign bus.wb_address = wb_address_q;
  assign bus.wb_exc     = wb_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_ldst_fu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_ldst_fu_pipe
// Purpose : Self-checking bench for ldst_fu_pipe (XLEN=32, TAG_W=6, DEPTH=4).
//           Single-op vectors from a table, then hand-written sequences for
//           backpressure, writeback priority, flush and asynchronous reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ldst_fu_pipe;
  import ldst_pkg::*;

  logic clk;
  logic rst_n;

  ldst_fu_pipe_if #(.XLEN(32), .TAG_W(6)) bus ();

  ldst_fu_pipe #(.XLEN(32), .TAG_W(6), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;

  typedef struct packed {
    logic [5:0]  tag;
    logic [31:0] res;
  } wb_t;
  wb_t wbq [$];

  typedef struct {
    logic [4:0]  opc;
    logic [3:0]  lst;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic [5:0]  tag;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_exc;
    logic [31:0] exp_res;
    logic [31:0] exp_eff;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  // Writeback and request-handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) wbq.push_back({bus.wb_tag, bus.wb_result});
    if (rst_n && bus.dc_req_valid && bus.dc_req_ready) req_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] opc, input logic [3:0] lst,
                       input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [5:0] tag);
    bus.valid      = 1'b1;
    bus.opcode     = opc;
    bus.ld_st_type = lst;
    bus.rs1        = rs1;
    bus.imm        = imm;
    bus.rs2        = rs2;
    bus.tag        = tag;
  endtask

  // Issue a word load and hold it until the unit accepts it
  task automatic issue_lw(input logic [31:0] addr, input logic [5:0] tag);
    int n;
    drive(5'h00, 4'h2, addr, 32'h0, 32'h0, tag);
    n = 0;
    while (!bus.ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("issue_timeout", 64'(bus.ready), 64'd1);
    step();
    bus.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n             = 1'b0;
    bus.valid         = 1'b0;
    bus.opcode        = '0;
    bus.ld_st_type    = '0;
    bus.rs1           = '0;
    bus.rs2           = '0;
    bus.imm           = '0;
    bus.tag           = '0;
    bus.flush         = 1'b0;
    bus.dc_req_ready  = 1'b1;
    bus.dc_resp_valid = 1'b0;
    bus.dc_resp_rdata = '0;

    //        opc    lst   rs1           imm           rs2           rdata         tag  req  addr          be    wdata         exc    res           eff
    vt[0]  = '{5'h00, 4'h2, 32'h00001000, 32'h00000004, 32'h0,        32'hDEADBEEF, 6'd1,  1'b1, 32'h00001004, 4'hF, 32'h0,        2'b00, 32'hDEADBEEF, 32'h00001004};
    vt[1]  = '{5'h03, 4'h0, 32'h00001000, 32'h00000003, 32'h0,        32'h80112233, 6'd2,  1'b1, 32'h00001000, 4'h8, 32'h0,        2'b00, 32'hFFFFFF80, 32'h00001003};
    vt[2]  = '{5'h00, 4'h4, 32'h00001000, 32'h00000003, 32'h0,        32'h80112233, 6'd3,  1'b1, 32'h00001000, 4'h8, 32'h0,        2'b00, 32'h00000080, 32'h00001003};
    vt[3]  = '{5'h10, 4'h1, 32'h00001000, 32'h00000002, 32'h0,        32'h80112233, 6'd4,  1'b1, 32'h00001000, 4'hC, 32'h0,        2'b00, 32'hFFFF8011, 32'h00001002};
    vt[4]  = '{5'h00, 4'hD, 32'h00001000, 32'h00000002, 32'h0,        32'h80112233, 6'd5,  1'b1, 32'h00001000, 4'hC, 32'h0,        2'b00, 32'h00008011, 32'h00001002};
    vt[5]  = '{5'h00, 4'h0, 32'h00001000, 32'h00000000, 32'h0,        32'h80112233, 6'd6,  1'b1, 32'h00001000, 4'h1, 32'h0,        2'b00, 32'h00000033, 32'h00001000};
    vt[6]  = '{5'h00, 4'h1, 32'h00001000, 32'h00000000, 32'h0,        32'h0000F00F, 6'd7,  1'b1, 32'h00001000, 4'h3, 32'h0,        2'b00, 32'hFFFFF00F, 32'h00001000};
    vt[7]  = '{5'h08, 4'h1, 32'h00002000, 32'h00000002, 32'h00001234, 32'h0,        6'd8,  1'b1, 32'h00002000, 4'hC, 32'h12340000, 2'b00, 32'h0,        32'h00002002};
    vt[8]  = '{5'h0F, 4'h0, 32'h00002000, 32'h00000001, 32'hFFFFFFAB, 32'h0,        6'd9,  1'b1, 32'h00002000, 4'h2, 32'hFFFFAB00, 2'b00, 32'h0,        32'h00002001};
    vt[9]  = '{5'h08, 4'h2, 32'h00003010, 32'hFFFFFFF0, 32'hCAFEBABE, 32'h0,        6'd10, 1'b1, 32'h00003000, 4'hF, 32'hCAFEBABE, 2'b00, 32'h0,        32'h00003000};
    vt[10] = '{5'h00, 4'h2, 32'h00001000, 32'h00000002, 32'h0,        32'h0,        6'd11, 1'b0, 32'h0,        4'h0, 32'h0,        2'b01, 32'h0,        32'h00001002};
    vt[11] = '{5'h00, 4'h3, 32'h00001000, 32'h00000000, 32'h0,        32'h0,        6'd12, 1'b0, 32'h0,        4'h0, 32'h0,        2'b10, 32'h0,        32'h00001000};
    vt[12] = '{5'h08, 4'h1, 32'h00002001, 32'h00000000, 32'h00005555, 32'h0,        6'd13, 1'b0, 32'h0,        4'h0, 32'h0,        2'b01, 32'h0,        32'h00002001};
    vt[13] = '{5'h00, 4'h2, 32'hFFFFFFFC, 32'h00000008, 32'h0,        32'h01234567, 6'd14, 1'b1, 32'h00000004, 4'hF, 32'h0,        2'b00, 32'h01234567, 32'h00000004};
    vt[14] = '{5'h08, 4'h3, 32'h00001001, 32'h00000000, 32'h0,        32'h0,        6'd15, 1'b0, 32'h0,        4'h0, 32'h0,        2'b10, 32'h0,        32'h00001001};
    vt[15] = '{5'h00, 4'h8, 32'h00001000, 32'h00000001, 32'h0,        32'h8011A233, 6'd16, 1'b1, 32'h00001000, 4'h2, 32'h0,        2'b00, 32'hFFFFFFA2, 32'h00001001};
    vt[16] = '{5'h18, 4'h0, 32'h00002000, 32'h00000003, 32'h0000005A, 32'h0,        6'd17, 1'b1, 32'h00002000, 4'h8, 32'h5A000000, 2'b00, 32'h0,        32'h00002003};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     64'(bus.ready),        64'd1);
    chk("rst_req_valid", 64'(bus.dc_req_valid), 64'd0);
    chk("rst_req_be",    64'(bus.dc_req_be),    64'd0);
    chk("rst_wb_valid",  64'(bus.wb_valid),     64'd0);
    chk("rst_wb_result", 64'(bus.wb_result),    64'd0);
    rst_n = 1'b1;

    // ---------------- table-driven single ops ----------------
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].opc, vt[i].lst, vt[i].rs1, vt[i].imm, vt[i].rs2, vt[i].tag);
      step();
      bus.valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d.req_valid", i), 64'(bus.dc_req_valid), 64'(vt[i].exp_req));
      if (vt[i].exp_req) begin
        chk($sformatf("v%0d.req_addr", i), 64'(bus.dc_req_addr), 64'(vt[i].exp_addr));
        chk($sformatf("v%0d.req_be", i),   64'(bus.dc_req_be),   64'(vt[i].exp_be));
        chk($sformatf("v%0d.req_we", i),   64'(bus.dc_req_we),   64'(vt[i].opc[3]));
        if (vt[i].opc[3])
          chk($sformatf("v%0d.req_wdata", i), 64'(bus.dc_req_wdata), 64'(vt[i].exp_wdata));
      end
      step();
      if (vt[i].exp_req && !vt[i].opc[3]) begin
        bus.dc_resp_valid = 1'b1;
        bus.dc_resp_rdata = vt[i].rdata;
        step();
        bus.dc_resp_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("v%0d.wb_valid", i),   64'(bus.wb_valid),   64'd1);
      chk($sformatf("v%0d.wb_tag", i),     64'(bus.wb_tag),     64'(vt[i].tag));
      chk($sformatf("v%0d.wb_result", i),  64'(bus.wb_result),  64'(vt[i].exp_res));
      chk($sformatf("v%0d.wb_address", i), 64'(bus.wb_address), 64'(vt[i].exp_eff));
      chk($sformatf("v%0d.wb_exc", i),     64'(bus.wb_exc),     64'(vt[i].exp_exc));
      step();
      @(negedge clk);
      chk($sformatf("v%0d.wb_pulse", i), 64'(bus.wb_valid), 64'd0);
    end

    // ---------------- store blocked by D$ backpressure ----------------
    bus.dc_req_ready = 1'b0;
    drive(5'h08, 4'h2, 32'h00005000, 32'h0, 32'h00000011, 6'd30);
    step();
    bus.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("blk_req_valid", 64'(bus.dc_req_valid), 64'd1);
      chk("blk_req_addr",  64'(bus.dc_req_addr),  64'h5000);
      chk("blk_ready",     64'(bus.ready),        64'd0);
      chk("blk_wb_valid",  64'(bus.wb_valid),     64'd0);
      step();
    end
    bus.dc_req_ready = 1'b1;
    step();
    @(negedge clk);
    chk("blk_wb_valid_after", 64'(bus.wb_valid), 64'd1);
    chk("blk_wb_tag",         64'(bus.wb_tag),   64'd30);
    step();

    // ---------------- response beats a store to the writeback slot ----------------
    wbq.delete();
    drive(5'h00, 4'h2, 32'h00001000, 32'h0, 32'h0, 6'd20);
    step();
    drive(5'h08, 4'h2, 32'h00002000, 32'h0, 32'h00000099, 6'd21);
    step();
    bus.valid         = 1'b0;
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_rdata = 32'h00000077;
    @(negedge clk);
    chk("prio_store_held", 64'(bus.dc_req_valid), 64'd0);
    step();
    bus.dc_resp_valid = 1'b0;
    repeat (3) step();
    chk("prio_wb_count", 64'(wbq.size()), 64'd2);
    if (wbq.size() == 2) begin
      chk("prio_first_tag",  64'(wbq[0].tag), 64'd20);
      chk("prio_first_res",  64'(wbq[0].res), 64'h77);
      chk("prio_second_tag", 64'(wbq[1].tag), 64'd21);
      chk("prio_second_res", 64'(wbq[1].res), 64'h0);
    end

    // ---------------- five loads into a four-entry buffer ----------------
    wbq.delete();
    req_cnt = 0;
    for (int k = 0; k < 5; k++) issue_lw(32'h00004000 + 32'(4 * k), 6'(10 + k));
    repeat (4) step();
    @(negedge clk);
    chk("full_req_count", 64'(req_cnt),          64'd4);
    chk("full_ready",     64'(bus.ready),        64'd0);
    chk("full_req_valid", 64'(bus.dc_req_valid), 64'd0);
    chk("full_no_wb",     64'(wbq.size()),       64'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      bus.dc_resp_valid = 1'b1;
      bus.dc_resp_rdata = 32'hA0000000 + 32'(k);
      step();
    end
    bus.dc_resp_valid = 1'b0;
    repeat (3) step();
    chk("full_req_total", 64'(req_cnt),    64'd5);
    chk("full_wb_count",  64'(wbq.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < wbq.size()) begin
        chk($sformatf("full_wb%0d_tag", k), 64'(wbq[k].tag), 64'(10 + k));
        chk($sformatf("full_wb%0d_res", k), 64'(wbq[k].res), 64'(32'hA0000000 + 32'(k)));
      end
    end

    // ---------------- flush with three loads outstanding ----------------
    wbq.delete();
    for (int k = 0; k < 3; k++) issue_lw(32'h00005000 + 32'(4 * k), 6'(40 + k));
    repeat (2) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.dc_resp_valid = 1'b1;
      bus.dc_resp_rdata = 32'h0BAD0000 + 32'(k);
      step();
    end
    // one more response with nothing outstanding must be ignored
    step();
    bus.dc_resp_valid = 1'b0;
    repeat (2) step();
    chk("flush_no_wb", 64'(wbq.size()), 64'd0);
    issue_lw(32'h00006000, 6'd43);
    step();
    bus.dc_resp_valid = 1'b1;
    bus.dc_resp_rdata = 32'h13579BDF;
    step();
    bus.dc_resp_valid = 1'b0;
    repeat (2) step();
    chk("post_flush_count", 64'(wbq.size()), 64'd1);
    if (wbq.size() == 1) begin
      chk("post_flush_tag", 64'(wbq[0].tag), 64'd43);
      chk("post_flush_res", 64'(wbq[0].res), 64'h13579BDF);
    end

    // ---------------- asynchronous reset during a stall ----------------
    bus.dc_req_ready = 1'b0;
    drive(5'h08, 4'h2, 32'h00007000, 32'h0, 32'h00000001, 6'd50);
    step();
    bus.valid = 1'b0;
    chk("stall_req_valid", 64'(bus.dc_req_valid), 64'd1);
    chk("stall_ready",     64'(bus.ready),        64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 64'(bus.dc_req_valid), 64'd0);
    chk("arst_req_be",    64'(bus.dc_req_be),    64'd0);
    chk("arst_req_addr",  64'(bus.dc_req_addr),  64'd0);
    chk("arst_ready",     64'(bus.ready),        64'd1);
    chk("arst_wb_valid",  64'(bus.wb_valid),     64'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
